// File: rtl/mux2a1_descp_condl2_pkg.sv
// rtl/mux2a1_descp_condl2_pkg.sv - shared FSM encoding and idle symbol for the L2 serialiser
package mux2a1_descp_condl2_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } l2_state_t;

  // Comma-like idle symbol shared with L1 and the receive side.
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;

endpackage

// File: rtl/mux2a1_descp_condl2_slot_select.sv
// rtl/mux2a1_descp_condl2_slot_select.sv - 2:1 slot pick with idle-symbol substitution
module mux2a1_descp_condl2_slot_select
  import mux2a1_descp_condl2_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic              sel_hold,
  input  logic              slot_en,
  input  logic [DATA_W:0]   lane0_slot,
  input  logic [DATA_W:0]   hold_slot,
  output logic [DATA_W-1:0] slot_data,
  output logic              slot_valid
);

  logic [DATA_W:0] picked;

  // Slot word is {valid, data}; a disabled or invalid slot becomes the idle symbol.
  always_comb begin
    picked     = sel_hold ? hold_slot : lane0_slot;
    slot_valid = picked[DATA_W] & slot_en;
    slot_data  = slot_valid ? picked[DATA_W-1:0] : IDLE_BYTE;
  end

endmodule

// File: rtl/mux2a1_descp_condl2.sv
// rtl/mux2a1_descp_condl2.sv - L2 2:1 byte serialiser with link-activity FSM, byte counter and lane-order flag
module mux2a1_descp_condl2
  import mux2a1_descp_condl2_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT,
  parameter int                CNT_W     = 16
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0_muxL2,
  input  logic [DATA_W-1:0] data_in1_muxL2,
  input  logic              valid0,
  input  logic              valid1,
  output logic [DATA_W-1:0] dataout_muxL2,
  output logic              validout,
  output logic              active,
  output logic [CNT_W-1:0]  byte_count,
  output logic              lane_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  l2_state_t         state, state_nxt;
  logic              miss, miss_nxt;
  logic              phase;
  logic [DATA_W:0]   hold_q;
  logic              capture;
  logic              any_valid;
  logic              slot_en;
  logic [DATA_W-1:0] slot_data;
  logic              slot_valid;
  logic [DATA_W-1:0] dout_q;
  logic              vout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  assign capture   = ~phase;
  assign any_valid = valid0 | valid1;

  // Decisions use the pre-edge state; a capture that wakes the link is still emitted.
  always_comb begin
    state_nxt = state;
    miss_nxt  = miss;
    slot_en   = (state == ST_RUN);
    if (capture) begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            state_nxt = ST_RUN;
            miss_nxt  = 1'b0;
            slot_en   = 1'b1;
          end
        end
        ST_RUN: begin
          if (any_valid) begin
            miss_nxt = 1'b0;
          end else if (miss) begin
            state_nxt = ST_IDLE;
            miss_nxt  = 1'b0;
          end else begin
            miss_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          miss_nxt  = 1'b0;
        end
      endcase
    end
  end

  mux2a1_descp_condl2_slot_select #(
    .DATA_W    (DATA_W),
    .IDLE_BYTE (IDLE_BYTE)
  ) u_slot_select (
    .sel_hold   (phase),
    .slot_en    (slot_en),
    .lane0_slot ({valid0, data_in0_muxL2}),
    .hold_slot  (hold_q),
    .slot_data  (slot_data),
    .slot_valid (slot_valid)
  );

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state  <= ST_IDLE;
      miss   <= 1'b0;
      phase  <= 1'b0;
      hold_q <= '0;
      dout_q <= IDLE_BYTE;
      vout_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      miss   <= miss_nxt;
      phase  <= ~phase;
      dout_q <= slot_data;
      vout_q <= slot_valid;
      if (capture) begin
        hold_q <= {valid1, data_in1_muxL2};
        if (valid1 && !valid0) begin
          err_q <= 1'b1;
        end
      end
      if (slot_valid && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign dataout_muxL2 = dout_q;
  assign validout      = vout_q;
  assign active        = (state == ST_RUN);
  assign byte_count    = cnt_q;
  assign lane_err      = err_q;

endmodule

// File: tb/tb_mux2a1_descp_condl2.sv
// tb/tb_mux2a1_descp_condl2.sv - directed self-checking bench for the L2 serialiser
module tb_mux2a1_descp_condl2;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  d0, d1;
  logic        v0, v1;
  logic [7:0]  dout, dout4;
  logic        vout, vout4;
  logic        act, act4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;
  logic        err, err4;

  int tests = 0;
  int fails = 0;

  always #5 clk_4f = ~clk_4f;

  mux2a1_descp_condl2 #(.DATA_W(8), .IDLE_BYTE(8'hBC), .CNT_W(16)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_in0_muxL2(d0), .data_in1_muxL2(d1), .valid0(v0), .valid1(v1),
    .dataout_muxL2(dout), .validout(vout), .active(act),
    .byte_count(cnt), .lane_err(err)
  );

  mux2a1_descp_condl2 #(.DATA_W(8), .IDLE_BYTE(8'hBC), .CNT_W(4)) dut4 (
    .clk_4f(clk_4f), .reset(reset),
    .data_in0_muxL2(d0), .data_in1_muxL2(d1), .valid0(v0), .valid1(v1),
    .dataout_muxL2(dout4), .validout(vout4), .active(act4),
    .byte_count(cnt4), .lane_err(err4)
  );

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic cap_edge(input logic [7:0] a, input logic [7:0] b,
                          input logic va, input logic vb);
    d0 = a; d1 = b; v0 = va; v1 = vb;
    step();
  endtask

  // Garbage on the non-capture edge must be ignored.
  task automatic hold_edge();
    d0 = 8'hEE; d1 = 8'hDD; v0 = 1'b1; v1 = 1'b1;
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    d0 = 8'h00; d1 = 8'h00; v0 = 1'b0; v1 = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d0 = 8'h00; d1 = 8'h00; v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if ({dout, vout, act, cnt, err} !== {8'hBC, 1'b0, 1'b0, 16'd0, 1'b0}) begin
        $display("FAIL reset_state cyc=%0d got dout=%h v=%b act=%b cnt=%0d err=%b want BC/0/0/0/0",
                 i, dout, vout, act, cnt, err);
        fails++;
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    cap_edge(8'h11, 8'h22, 1'b1, 1'b1);
    tests++;
    if ({act, vout, dout} !== {1'b1, 1'b1, 8'h11}) begin
      $display("FAIL single_lane0 got act=%b v=%b d=%h want 1/1/11", act, vout, dout);
      fails++;
    end
    hold_edge();
    tests++;
    if ({vout, dout, cnt} !== {1'b1, 8'h22, 16'd2}) begin
      $display("FAIL single_lane1 got v=%b d=%h cnt=%0d want 1/22/2", vout, dout, cnt);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      b = 8'(2 * k + 1);
      cap_edge(b, b + 8'd1, 1'b1, 1'b1);
      tests++;
      if ({vout, dout} !== {1'b1, b}) begin
        $display("FAIL b2b_lane0 k=%0d got v=%b d=%h want 1/%h", k, vout, dout, b);
        fails++;
      end
      hold_edge();
      tests++;
      if ({vout, dout} !== {1'b1, b + 8'd1}) begin
        $display("FAIL b2b_lane1 k=%0d got v=%b d=%h want 1/%h", k, vout, dout, b + 8'd1);
        fails++;
      end
    end
    tests++;
    if (cnt !== 16'd8) begin
      $display("FAIL b2b_count got %0d want 8", cnt);
      fails++;
    end
  endtask

  task automatic test_gap_and_drop();
    apply_reset();
    cap_edge(8'hA1, 8'hA2, 1'b1, 1'b1);
    hold_edge();
    cap_edge(8'h77, 8'h88, 1'b0, 1'b0);
    tests++;
    if ({act, vout, dout} !== {1'b1, 1'b0, 8'hBC}) begin
      $display("FAIL gap_lane0 got act=%b v=%b d=%h want 1/0/BC", act, vout, dout);
      fails++;
    end
    hold_edge();
    tests++;
    if ({act, vout, dout} !== {1'b1, 1'b0, 8'hBC}) begin
      $display("FAIL gap_lane1 got act=%b v=%b d=%h want 1/0/BC", act, vout, dout);
      fails++;
    end
    cap_edge(8'hB1, 8'hB2, 1'b1, 1'b1);
    hold_edge();
    tests++;
    if ({act, vout, dout} !== {1'b1, 1'b1, 8'hB2}) begin
      $display("FAIL gap_resume got act=%b v=%b d=%h want 1/1/B2", act, vout, dout);
      fails++;
    end
    cap_edge(8'h00, 8'h00, 1'b0, 1'b0);
    tests++;
    if ({act, vout, dout} !== {1'b1, 1'b0, 8'hBC}) begin
      $display("FAIL first_miss got act=%b v=%b d=%h want 1/0/BC", act, vout, dout);
      fails++;
    end
    hold_edge();
    cap_edge(8'h00, 8'h00, 1'b0, 1'b0);
    tests++;
    if ({act, vout, dout, cnt} !== {1'b0, 1'b0, 8'hBC, 16'd4}) begin
      $display("FAIL second_miss got act=%b v=%b d=%h cnt=%0d want 0/0/BC/4", act, vout, dout, cnt);
      fails++;
    end
  endtask

  task automatic test_lane_err();
    apply_reset();
    cap_edge(8'hAA, 8'h55, 1'b0, 1'b1);
    tests++;
    if ({act, err, vout, dout} !== {1'b1, 1'b1, 1'b0, 8'hBC}) begin
      $display("FAIL lerr_lane0 got act=%b err=%b v=%b d=%h want 1/1/0/BC", act, err, vout, dout);
      fails++;
    end
    hold_edge();
    tests++;
    if ({vout, dout, cnt} !== {1'b1, 8'h55, 16'd1}) begin
      $display("FAIL lerr_lane1 got v=%b d=%h cnt=%0d want 1/55/1", vout, dout, cnt);
      fails++;
    end
    cap_edge(8'h01, 8'h02, 1'b1, 1'b1);
    tests++;
    if ({err, vout, dout} !== {1'b1, 1'b1, 8'h01}) begin
      $display("FAIL lerr_sticky got err=%b v=%b d=%h want 1/1/01", err, vout, dout);
      fails++;
    end
    hold_edge();
    apply_reset();
    tests++;
    if (err !== 1'b0) begin
      $display("FAIL lerr_clear got %b want 0", err);
      fails++;
    end
  endtask

  task automatic test_saturate_and_mid_reset();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      cap_edge(8'(8'h40 + k), 8'(8'h50 + k), 1'b1, 1'b1);
      if (k == 7) begin
        tests++;
        if (cnt4 !== 4'd15) begin
          $display("FAIL sat_lane0 got %0d want 15", cnt4);
          fails++;
        end
      end
      hold_edge();
      if (k == 6) begin
        tests++;
        if (cnt4 !== 4'd14) begin
          $display("FAIL sat_before got %0d want 14", cnt4);
          fails++;
        end
      end
    end
    tests++;
    if ({cnt4, cnt} !== {4'd15, 16'd16}) begin
      $display("FAIL sat_hold got cnt4=%0d cnt=%0d want 15/16", cnt4, cnt);
      fails++;
    end
    cap_edge(8'h33, 8'h44, 1'b1, 1'b1);
    tests++;
    if ({vout, dout} !== {1'b1, 8'h33}) begin
      $display("FAIL mid_lane0 got v=%b d=%h want 1/33", vout, dout);
      fails++;
    end
    reset = 1'b1;
    hold_edge();
    tests++;
    if ({dout, vout, act, cnt, err, cnt4} !== {8'hBC, 1'b0, 1'b0, 16'd0, 1'b0, 4'd0}) begin
      $display("FAIL mid_reset got d=%h v=%b act=%b cnt=%0d err=%b cnt4=%0d want BC/0/0/0/0/0",
               dout, vout, act, cnt, err, cnt4);
      fails++;
    end
    reset = 1'b0;
    cap_edge(8'h00, 8'h00, 1'b0, 1'b0);
    tests++;
    if ({vout, dout} !== {1'b0, 8'hBC}) begin
      $display("FAIL post_reset0 got v=%b d=%h want 0/BC", vout, dout);
      fails++;
    end
    d0 = 8'h00; d1 = 8'h00; v0 = 1'b0; v1 = 1'b0;
    step();
    tests++;
    if ({vout, dout, act} !== {1'b0, 8'hBC, 1'b0}) begin
      $display("FAIL post_reset1 got v=%b d=%h act=%b want 0/BC/0", vout, dout, act);
      fails++;
    end
  endtask

  initial begin
    reset = 1'b1;
    d0 = 8'h00; d1 = 8'h00; v0 = 1'b0; v1 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap_and_drop();
    test_lane_err();
    test_saturate_and_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
